rst_seq_sync: RTL and testbench

RST_SEQ_SYNC -- requirements
Module: rst_seq_sync

---
 rtl/rst_seq_sync.sv | 146 ++++++++++++++
 tb/tb_rst_seq_sync.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchronizer and release sequencer.
//
// RST is asserted asynchronously and released through a NUM_STAGES-deep
// synchronizer chain. Once the synchronized release (SREL) is seen, all
// outputs stay in reset for STRETCH cycles. The channels then release one
// after another, GAP cycles apart. A software request clears every channel
// and restarts the stretch phase.
//
// Ports:
//   CLK        - clock, rising edge
//   RST        - asynchronous, active-low reset
//   SW_RST_REQ - synchronous software reset request, active-high
//   SYNC_RST   - per-channel active-low resets; bit i is released i-th
//   RST_DONE   - high once every channel is released
module rst_seq_sync #(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned STRETCH    = 8,
   parameter int unsigned GAP        = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SW_RST_REQ,
   output logic [NUM_CH-1:0] SYNC_RST,
   output logic              RST_DONE
);

   localparam int unsigned ST_W = $clog2(STRETCH + 1);
   localparam int unsigned GP_W = $clog2(GAP + 1);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ASSERT,
      HOLD,
      RELEASE,
      DONE
   } state_t;

   logic [NUM_STAGES-1:0] chain_q, chain_d;
   logic                  srel_q, srel_d;
   state_t                state_q, state_d;
   logic [ST_W-1:0]       hold_q, hold_d;
   logic [GP_W-1:0]       gap_q, gap_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [NUM_CH-1:0]     sync_rst_q, sync_rst_d;
   logic                  rst_done_q, rst_done_d;

   assign srel_q = chain_q[NUM_STAGES-1];

   always_comb begin
      // Shift a 1 into stage 0; with one stage this is simply constant 1.
      chain_d = (chain_q << 1) | NUM_STAGES'(1);
      // Look ahead at the last stage's input so HOLD is entered on the very
      // edge where SREL becomes 1.
      srel_d  = chain_d[NUM_STAGES-1];

      state_d    = state_q;
      hold_d     = hold_q;
      gap_d      = gap_q;
      ch_d       = ch_q;
      sync_rst_d = sync_rst_q;
      rst_done_d = rst_done_q;

      case (state_q)
         ASSERT: begin
            if (srel_d) begin
               state_d = HOLD;
               hold_d  = ST_W'(1);
            end
         end
         HOLD: begin
            if (hold_q == ST_W'(STRETCH)) begin
               sync_rst_d = NUM_CH'(1);
               hold_d     = '0;
               if (NUM_CH == 1) begin
                  state_d    = DONE;
                  rst_done_d = 1'b1;
               end else begin
                  state_d = RELEASE;
                  gap_d   = GP_W'(1);
                  ch_d    = CH_W'(1);
               end
            end else begin
               hold_d = hold_q + ST_W'(1);
            end
         end
         RELEASE: begin
            if (gap_q == GP_W'(GAP)) begin
               // Released bits form a contiguous run from bit 0, so shifting
               // in a 1 releases exactly the next channel.
               sync_rst_d = (sync_rst_q << 1) | NUM_CH'(1);
               gap_d      = GP_W'(1);
               if (ch_q == CH_W'(NUM_CH - 1)) begin
                  state_d    = DONE;
                  rst_done_d = 1'b1;
                  gap_d      = '0;
                  ch_d       = '0;
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end else begin
               gap_d = gap_q + GP_W'(1);
            end
         end
         DONE: begin
         end
         default: begin
            state_d = ASSERT;
         end
      endcase

      // srel_q is 0 only in ASSERT, so this gate also drops requests there.
      if (SW_RST_REQ && srel_q) begin
         state_d    = HOLD;
         hold_d     = ST_W'(1);
         gap_d      = '0;
         ch_d       = '0;
         sync_rst_d = '0;
         rst_done_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         chain_q    <= '0;
         state_q    <= ASSERT;
         hold_q     <= '0;
         gap_q      <= '0;
         ch_q       <= '0;
         sync_rst_q <= '0;
         rst_done_q <= 1'b0;
      end else begin
         chain_q    <= chain_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         gap_q      <= gap_d;
         ch_q       <= ch_d;
         sync_rst_q <= sync_rst_d;
         rst_done_q <= rst_done_d;
      end
   end

   assign SYNC_RST = sync_rst_q;
   assign RST_DONE = rst_done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
`timescale 1ns/1ps
// Testbench for rst_seq_sync: a default instance and a minimum-size
// instance share the same RST / SW_RST_REQ stimulus. Expected outputs per
// edge come from a release-time model and are queued for a separate monitor.
module tb_rst_seq_sync;

   localparam int NS_A = 2, CH_A = 4, ST_A = 8, GP_A = 4;
   localparam int NS_B = 1, CH_B = 1, ST_B = 1, GP_B = 1;

   logic       clk;
   logic       rst_n;
   logic       sw;
   logic [3:0] a_sync;
   logic       a_done;
   logic [0:0] b_sync;
   logic       b_done;

   rst_seq_sync #(.NUM_STAGES(NS_A), .NUM_CH(CH_A), .STRETCH(ST_A), .GAP(GP_A)) dut_a (
      .CLK(clk), .RST(rst_n), .SW_RST_REQ(sw), .SYNC_RST(a_sync), .RST_DONE(a_done));

   rst_seq_sync #(.NUM_STAGES(NS_B), .NUM_CH(CH_B), .STRETCH(ST_B), .GAP(GP_B)) dut_b (
      .CLK(clk), .RST(rst_n), .SW_RST_REQ(sw), .SYNC_RST(b_sync), .RST_DONE(b_done));

   typedef struct {
      int          edge_no;
      logic [15:0] a_s;
      logic        a_d;
      logic [15:0] b_s;
      logic        b_d;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   prog = 0;   // number of the last edge whose inputs were driven
   int   base = 0;   // edge before "edge 1" of the current release
   bit   started = 0;
   bit   stim_done = 0;
   bit   mon_done = 0;
   int   first1 [2];  // first edge sampling RST=1, -1 while in reset
   int   anchor [2];  // edge where SYNC_RST[0] is due, -1 if none

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Expected outputs after edge g, from release times alone.
   function automatic void model_edge(input int d, input int g, input logic r, input logic s,
                                      output logic [15:0] so, output logic dn);
      int ns, nch, st, gp, k;
      ns  = (d == 0) ? NS_A : NS_B;
      nch = (d == 0) ? CH_A : CH_B;
      st  = (d == 0) ? ST_A : ST_B;
      gp  = (d == 0) ? GP_A : GP_B;
      if (!r) begin
         first1[d] = -1;
         anchor[d] = -1;
      end else if (first1[d] < 0) begin
         first1[d] = g;
         anchor[d] = g + ns - 1 + st;
      end else if (s && g > first1[d] + ns - 1) begin
         anchor[d] = g + st;
      end
      if (anchor[d] < 0 || g < anchor[d]) k = 0;
      else k = 1 + (g - anchor[d]) / gp;
      if (k > nch) k = nch;
      so = 16'((1 << k) - 1);
      dn = (k == nch);
   endfunction

   function automatic void model_async();
      for (int d = 0; d < 2; d++) begin
         first1[d] = -1;
         anchor[d] = -1;
      end
   endfunction

   task automatic step(input logic r, input logic s);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      sw    = s;
      prog++;
      e.edge_no = prog;
      model_edge(0, prog, r, s, e.a_s, e.a_d);
      model_edge(1, prog, r, s, e.b_s, e.b_d);
      q.push_back(e);
      started = 1;
   endtask

   task automatic drive(input int last, input logic r, input logic s);
      while (prog - base < last) step(r, s);
   endtask

   task automatic chk(input string nm, input logic [3:0] sa, input logic da,
                      input logic sb, input logic db);
      @(posedge clk);
      #2;
      cmp({nm, " A SYNC_RST"}, 16'(a_sync), 16'(sa));
      cmp({nm, " A RST_DONE"}, 16'(a_done), 16'(da));
      cmp({nm, " B SYNC_RST"}, 16'(b_sync), 16'(sb));
      cmp({nm, " B RST_DONE"}, 16'(b_done), 16'(db));
   endtask

   // 0.3-cycle RST low pulse after the pending edge, not spanning any edge.
   task automatic pulse();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #2;
      cmp("async pulse A SYNC_RST", 16'(a_sync), 16'(0));
      cmp("async pulse A RST_DONE", 16'(a_done), 16'(0));
      cmp("async pulse B SYNC_RST", 16'(b_sync), 16'(0));
      #4;
      rst_n = 1'b1;
      model_async();
   endtask

   // Monitor: one expected entry per driven edge.
   initial begin
      exp_t e;
      wait (started);
      forever begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            if (stim_done) break;
            checks++;
            errors++;
            $display("FAIL scoreboard underflow: got empty queue expected an entry");
         end else begin
            e = q.pop_front();
            cmp($sformatf("edge %0d A SYNC_RST", e.edge_no), 16'(a_sync), e.a_s);
            cmp($sformatf("edge %0d A RST_DONE", e.edge_no), 16'(a_done), 16'(e.a_d));
            cmp($sformatf("edge %0d B SYNC_RST", e.edge_no), 16'(b_sync), e.b_s);
            cmp($sformatf("edge %0d B RST_DONE", e.edge_no), 16'(b_done), 16'(e.b_d));
         end
      end
      mon_done = 1;
   end

   // Monotonic release order and RST_DONE equal to all-released, every cycle.
   always @(negedge clk) begin
      checks += 2;
      assert (((5'(a_sync) & (5'(a_sync) + 5'd1)) == 5'd0) && (a_done == (&a_sync)))
      else begin
         errors++;
         $display("FAIL invariant A: got sync %b done %b expected contiguous sync with done=&sync",
                  a_sync, a_done);
      end
      assert (((2'(b_sync) & (2'(b_sync) + 2'd1)) == 2'd0) && (b_done == (&b_sync)))
      else begin
         errors++;
         $display("FAIL invariant B: got sync %b done %b expected done=&sync", b_sync, b_done);
      end
   end

   initial begin
      int sw_left;
      logic s;
      model_async();
      rst_n = 1'b0;
      sw    = 1'b0;
      #1;
      cmp("reset A SYNC_RST", 16'(a_sync), 16'(0));
      cmp("reset A RST_DONE", 16'(a_done), 16'(0));
      cmp("reset B SYNC_RST", 16'(b_sync), 16'(0));

      // Power-on; requests during reset and on edge 1 must be ignored.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      base = prog;
      drive(1, 1'b1, 1'b1);
      drive(9, 1'b1, 1'b0);  chk("power-on @9", 4'b0000, 1'b0, 1'b1, 1'b1);
      drive(10, 1'b1, 1'b0); chk("power-on @10", 4'b0001, 1'b0, 1'b1, 1'b1);
      drive(14, 1'b1, 1'b0); chk("power-on @14", 4'b0011, 1'b0, 1'b1, 1'b1);
      drive(21, 1'b1, 1'b0); chk("power-on @21", 4'b0111, 1'b0, 1'b1, 1'b1);
      drive(22, 1'b1, 1'b0); chk("power-on @22", 4'b1111, 1'b1, 1'b1, 1'b1);

      // Single-cycle software request in DONE.
      drive(29, 1'b1, 1'b0);
      drive(30, 1'b1, 1'b1); chk("sw pulse @30", 4'b0000, 1'b0, 1'b0, 1'b0);
      drive(37, 1'b1, 1'b0); chk("sw pulse @37", 4'b0000, 1'b0, 1'b1, 1'b1);
      drive(38, 1'b1, 1'b0); chk("sw pulse @38", 4'b0001, 1'b0, 1'b1, 1'b1);
      drive(50, 1'b1, 1'b0); chk("sw pulse @50", 4'b1111, 1'b1, 1'b1, 1'b1);

      // Held software request over five edges.
      drive(59, 1'b1, 1'b0);
      drive(64, 1'b1, 1'b1); chk("sw held @64", 4'b0000, 1'b0, 1'b0, 1'b0);
      drive(71, 1'b1, 1'b0); chk("sw held @71", 4'b0000, 1'b0, 1'b1, 1'b1);
      drive(72, 1'b1, 1'b0); chk("sw held @72", 4'b0001, 1'b0, 1'b1, 1'b1);
      drive(83, 1'b1, 1'b0); chk("sw held @83", 4'b0111, 1'b0, 1'b1, 1'b1);
      drive(84, 1'b1, 1'b0); chk("sw held @84", 4'b1111, 1'b1, 1'b1, 1'b1);

      // Fresh reset, then a short async pulse mid-RELEASE.
      drive(89, 1'b0, 1'b0);
      base = prog;
      drive(15, 1'b1, 1'b0);
      pulse();
      drive(24, 1'b1, 1'b0); chk("restart @24", 4'b0000, 1'b0, 1'b1, 1'b1);
      drive(25, 1'b1, 1'b0); chk("restart @25", 4'b0001, 1'b0, 1'b1, 1'b1);
      drive(37, 1'b1, 1'b0); chk("restart @37", 4'b1111, 1'b1, 1'b1, 1'b1);

      // Randomized mix of requests, full-cycle resets and short pulses.
      sw_left = 0;
      for (int i = 0; i < 400; i++) begin
         if (sw_left == 0 && $urandom_range(0, 15) == 0) sw_left = $urandom_range(1, 4);
         s = (sw_left > 0);
         if (sw_left > 0) sw_left--;
         if ($urandom_range(0, 79) == 0) begin
            int len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) step(1'b0, s);
         end else if ($urandom_range(0, 99) == 0) begin
            step(1'b1, s);
            pulse();
         end else begin
            step(1'b1, s);
         end
      end

      stim_done = 1;
      repeat (4) @(negedge clk);
      checks++;
      if (!mon_done || q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
